// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between requesters and the shared logic-unit arbiter.
// Latency: none (wires only).
// Backpressure: req_ready per requester, rsp_ready on the shared response channel.
interface logic_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;

  // Requester / sink side
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered NOT/AND/OR/XOR unit among NUM_REQ requesters.
// Latency: accept at T, rsp_valid from T+2; one operation in flight, issue interval >= 3 cycles.
// Backpressure: response held stable until rsp_ready; no request is accepted until it drains.
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [1:0]            r_op;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [ID_W-1:0]       r_id;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [WIDTH-1:0]      r_rsp_data;

  logic                  w_any;
  logic [ID_W-1:0]       w_gnt;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_rr_next;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_req_ready;

  // Rotate an index by an offset, wrapping at NUM_REQ (not at 2**ID_W).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  function automatic logic [WIDTH-1:0] lu_eval(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = ~a;
      2'b01:   res = a & b;
      2'b10:   res = a | b;
      default: res = a ^ b;
    endcase
    return res;
  endfunction

  // Round-robin search: scan from the highest offset down so the closest valid requester to rr_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = wrap_add(r_rr_ptr, k);
      if (bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
    w_rr_next = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (bus.rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: a grant is only offered in IDLE and never while reset is held.
  always_comb begin
    w_req_ready = '0;
    w_accept    = 1'b0;
    if (rst_n && (r_state == IDLE) && w_any) begin
      w_accept           = 1'b1;
      w_req_ready[w_gnt] = 1'b1;
    end
  end

  // Capture the granted request, advance the pointer, compute and hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= bus.req_op[2*w_gnt +: 2];
        r_a      <= bus.req_a[WIDTH*w_gnt +: WIDTH];
        r_b      <= bus.req_b[WIDTH*w_gnt +: WIDTH];
        r_id     <= w_gnt;
        r_rr_ptr <= w_rr_next;
      end
      if (r_state == EXEC) begin
        r_rsp_data  <= lu_eval(r_op, r_a, r_b);
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == RESP) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a cycle model and response scoreboard.
// Latency: model tracks IDLE/EXEC/RESP and checks req_ready/rsp_* every cycle.
// Backpressure: bench toggles rsp_ready and holds requests until granted.
module tb_logic_unit_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  logic_unit_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int id; logic [WIDTH-1:0] data; } exp_t;
  typedef struct { int id; int cyc; } gnt_t;

  exp_t sbq[$];
  gnt_t glog[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int m_state = 0;
  int m_ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] lu(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Reference model: predicts grants, pushes expected results at accept, checks responses.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_rdy;
    int g;
    if (!rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      sbq.delete();
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id",    32'(bus.rsp_id), 0);
      chk("rst_rsp_data",  32'(bus.rsp_data), 0);
    end else begin
      exp_rdy = '0;
      g = -1;
      if (m_state == 0) begin
        for (int k = NUM_REQ - 1; k >= 0; k--)
          if (bus.req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      case (m_state)
        0: begin
          chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
          if (g >= 0) begin
            sbq.push_back('{g, lu(bus.req_op[2*g +: 2], bus.req_a[WIDTH*g +: WIDTH],
                                  bus.req_b[WIDTH*g +: WIDTH])});
            glog.push_back('{g, cyc});
            m_ptr   = (g + 1) % NUM_REQ;
            m_state = 1;
          end
        end
        1: begin
          chk("exec_rsp_valid", 32'(bus.rsp_valid), 0);
          m_state = 2;
        end
        default: begin
          chk("resp_rsp_valid", 32'(bus.rsp_valid), 1);
          if (sbq.size() == 0) begin
            chk("sb_nonempty", 0, 1);
          end else begin
            chk("rsp_id",   32'(bus.rsp_id), 32'(sbq[0].id));
            chk("rsp_data", 32'(bus.rsp_data), 32'(sbq[0].data));
            if (bus.rsp_ready) begin
              void'(sbq.pop_front());
              m_state = 0;
            end
          end
        end
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int k, input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_valid[k]          = v;
    bus.req_op[2*k +: 2]      = op;
    bus.req_a[WIDTH*k +: WIDTH] = a;
    bus.req_b[WIDTH*k +: WIDTH] = b;
  endtask

  // Wait (bounded) until requester k is offered req_ready, then step past the accepting edge.
  task automatic wait_grant(input int k);
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready[k]) break;
      n++;
      if (n > 40) begin
        chk("grant_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the response handshake and return what was transferred.
  task automatic wait_rsp(output logic [WIDTH-1:0] d, output int id);
    int n = 0;
    d = '0;
    id = -1;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        d  = bus.rsp_data;
        id = int'(bus.rsp_id);
        break;
      end
      n++;
      if (n > 40) begin
        chk("rsp_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]       ops[4];
    logic [WIDTH-1:0] exps[4];
    logic [WIDTH-1:0] d;
    int id;
    int gstart;
    int n;

    ops  = '{2'b01, 2'b10, 2'b11, 2'b00};
    exps = '{8'h30, 8'hFC, 8'hCC, 8'h0F};

    // Reset with every requester valid: no grant may be offered.
    bus.req_valid = '1;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single NOT on requester 1.
    set_req(1, 1'b1, 2'b00, 8'hA5, 8'h00);
    gstart = glog.size();
    wait_grant(1);
    set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
    chk("t1_grant_id", 32'(glog[gstart].id), 1);
    @(negedge clk);
    chk("t1_exec_valid", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    chk("t1_valid", 32'(bus.rsp_valid), 1);
    chk("t1_id",    32'(bus.rsp_id), 1);
    chk("t1_data",  32'(bus.rsp_data), 32'h5A);
    @(posedge clk);
    #1;

    // Every opcode on requester 0.
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, ops[i], 8'hF0, 8'h3C);
      wait_grant(0);
      set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
      wait_rsp(d, id);
      chk("t2_data", 32'(d), 32'(exps[i]));
      chk("t2_id",   32'(id), 0);
    end

    // Operand changed the cycle after accept must not leak into the result.
    set_req(2, 1'b1, 2'b00, 8'h01, 8'h00);
    wait_grant(2);
    set_req(2, 1'b0, 2'b00, 8'hFF, 8'hAA);
    wait_rsp(d, id);
    chk("t5_data", 32'(d), 32'hFE);
    chk("t5_id",   32'(id), 2);

    // Backpressure on requester 3, then all requesters contend continuously.
    bus.rsp_ready = 1'b0;
    set_req(3, 1'b1, 2'b11, 8'h55, 8'h0F);
    wait_grant(3);
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, 2'(k), 8'(8'h11 * (k + 1)), 8'hC3);
    gstart = glog.size();
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_valid",     32'(bus.rsp_valid), 1);
      chk("bp_id",        32'(bus.rsp_id), 3);
      chk("bp_data",      32'(bus.rsp_data), 32'h5A);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(bus.req_ready), 32'h1);
    n = 0;
    while (glog.size() < gstart + 8 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    chk("rr_grant_count_ok", 32'(glog.size() >= gstart + 8), 1);
    if (glog.size() >= gstart + 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("rr_order", 32'(glog[gstart + i].id), 32'(i % NUM_REQ));
        if (i > 0) chk("rr_interval", 32'(glog[gstart + i].cyc - glog[gstart + i - 1].cyc), 3);
      end
    end
    repeat (6) @(posedge clk);
    #1;

    // Reset during EXEC aborts the transaction; requester 0 wins afterwards.
    set_req(1, 1'b1, 2'b01, 8'hFF, 8'h0F);
    wait_grant(1);
    set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
    rst_n = 1'b0;
    set_req(3, 1'b1, 2'b10, 8'h0C, 8'h30);
    set_req(0, 1'b1, 2'b11, 8'hAA, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gstart = glog.size();
    wait_grant(0);
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    chk("t6_first_grant", 32'(glog[gstart].id), 0);
    wait_rsp(d, id);
    chk("t6_rsp0_id",   32'(id), 0);
    chk("t6_rsp0_data", 32'(d), 32'h55);
    wait_grant(3);
    set_req(3, 1'b0, 2'b00, 8'h00, 8'h00);
    wait_rsp(d, id);
    chk("t6_rsp3_id",   32'(id), 3);
    chk("t6_rsp3_data", 32'(d), 32'h3C);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
